tlp_tx_framer: RTL and testbench

Transmit-side TLP framer: accepts a memory-request descriptor plus an optional payload stream and emits a complete 3-DW-header PCIe TLP as a 32-bit dword stream with start/end-of-packet markers. It is the generator end of the TLP path that the TLP detector receives. It drives detector benches and loopback tests, and serves as the request source in the integrated design.

---
 rtl/tlp_pkg.sv | 28 ++
 rtl/tlp_hdr_builder.sv | 32 +++
 rtl/tlp_tx_framer.sv | 149 ++++++++++++++
 tb/tb_tlp_tx_framer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// Shared constants, header field positions and FSM state type for the TLP transmit framer.
package tlp_pkg;

  localparam logic [2:0] FMT_MRD3 = 3'b000;
  localparam logic [2:0] FMT_MWR3 = 3'b010;
  localparam logic [4:0] TYPE_MEM = 5'b00000;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  localparam int DW0_FMT_LSB  = 29;
  localparam int DW0_TYPE_LSB = 24;
  localparam int DW0_LEN_LSB  = 0;

  localparam int DW1_ID_LSB  = 16;
  localparam int DW1_TAG_LSB = 8;
  localparam int DW1_LBE_LSB = 4;
  localparam int DW1_FBE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_DATA
  } state_e;

endpackage

// File: rtl/tlp_hdr_builder.sv
// Combinational mapping from a latched request descriptor to the three 3-DW header dwords.
module tlp_hdr_builder
  import tlp_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [4:0]  type_i,
  input  logic [9:0]  len_i,
  input  logic [31:0] addr_i,
  input  logic [7:0]  tag_i,
  input  logic [15:0] id_i,
  output logic [31:0] dw0_o,
  output logic [31:0] dw1_o,
  output logic [31:0] dw2_o
);

  // TC, TD, EP and attr are all zero, so only fmt/type/len land in DW0.
  always_comb begin
    dw0_o = '0;
    dw0_o[DW0_FMT_LSB +: 3]   = fmt_i;
    dw0_o[DW0_TYPE_LSB +: 5]  = type_i;
    dw0_o[DW0_LEN_LSB +: 10]  = len_i;

    dw1_o = '0;
    dw1_o[DW1_ID_LSB +: 16]   = id_i;
    dw1_o[DW1_TAG_LSB +: 8]   = tag_i;
    dw1_o[DW1_LBE_LSB +: 4]   = (len_i == 10'd1) ? BE_NONE : BE_FULL;
    dw1_o[DW1_FBE_LSB +: 4]   = BE_FULL;
  end

  assign dw2_o = addr_i & 32'hFFFF_FFFC;

endmodule

// File: rtl/tlp_tx_framer.sv
// Transmit framer: turns a memory-request descriptor plus optional payload into a 3-DW-header TLP stream.
// state | meaning: IDLE accept descriptor; HDR0/1/2 present header dwords; DATA pass payload through.
module tlp_tx_framer
  import tlp_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_fmt,
  input  logic [4:0]           req_type,
  input  logic [9:0]           req_len,
  input  logic [31:0]          req_addr,
  input  logic [7:0]           req_tag,
  input  logic [15:0]          req_id,
  input  logic                 pay_valid,
  output logic                 pay_ready,
  input  logic [31:0]          pay_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [31:0]          tx_data,
  output logic                 tx_sop,
  output logic                 tx_eop,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] tlp_count
);

  localparam logic [9:0] LEN_MAX = 10'(MAX_LEN);

  state_e               state_q, state_d;
  logic                 ready_q;
  logic                 err_q, err_d;
  logic [9:0]           rem_q, rem_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2:0]           fmt_q;
  logic [4:0]           type_q;
  logic [9:0]           len_q;
  logic [31:0]          addr_q;
  logic [7:0]           tag_q;
  logic [15:0]          id_q;
  logic [31:0]          dw0, dw1, dw2;
  logic                 accept, legal;

  tlp_hdr_builder u_hdr (
    .fmt_i  (fmt_q),
    .type_i (type_q),
    .len_i  (len_q),
    .addr_i (addr_q),
    .tag_i  (tag_q),
    .id_i   (id_q),
    .dw0_o  (dw0),
    .dw1_o  (dw1),
    .dw2_o  (dw2)
  );

  assign accept = (state_q == ST_IDLE) && ready_q && req_valid;
  assign legal  = ((req_fmt == FMT_MRD3) || (req_fmt == FMT_MWR3)) &&
                  (req_type == TYPE_MEM) && (req_len != 10'd0) && (req_len <= LEN_MAX);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    err_d     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    pay_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (legal) begin
            state_d = ST_HDR0;
            rem_d   = req_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HDR0: begin
        tx_valid = 1'b1;
        tx_data  = dw0;
        tx_sop   = 1'b1;
        if (tx_ready) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = dw1;
        if (tx_ready) state_d = ST_HDR2;
      end
      ST_HDR2: begin
        tx_valid = 1'b1;
        tx_data  = dw2;
        tx_eop   = (fmt_q == FMT_MRD3);
        if (tx_ready) state_d = (fmt_q == FMT_MRD3) ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        // Payload is a straight pass-through; only eop comes from registered state.
        tx_valid  = pay_valid;
        tx_data   = pay_data;
        pay_ready = tx_ready;
        tx_eop    = (rem_q == 10'd1);
        if (pay_valid && tx_ready) begin
          rem_d = rem_q - 10'd1;
          if (rem_q == 10'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      fmt_q   <= '0;
      type_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      err_q   <= err_d;
      rem_q   <= rem_d;
      if (tx_valid && tx_ready && tx_eop) cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        fmt_q  <= req_fmt;
        type_q <= req_type;
        len_q  <= req_len;
        addr_q <= req_addr;
        tag_q  <= req_tag;
        id_q   <= req_id;
      end
    end
  end

  assign req_ready = ready_q;
  assign err       = err_q;
  assign tlp_count = cnt_q;

endmodule

// File: tb/tb_tlp_tx_framer.sv
// Self-checking bench for tlp_tx_framer: directed spec vectors plus randomized TLPs against a dword-list model.
module tb_tlp_tx_framer;

  typedef logic [31:0] dwq_t [$];

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_fmt;
  logic [4:0]  req_type;
  logic [9:0]  req_len;
  logic [31:0] req_addr;
  logic [7:0]  req_tag;
  logic [15:0] req_id;
  logic        pay_valid, pay_ready;
  logic [31:0] pay_data;
  logic        tx_valid, tx_ready;
  logic [31:0] tx_data;
  logic        tx_sop, tx_eop, err;
  logic [7:0]  tlp_count;

  tlp_tx_framer #(.MAX_LEN(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt), .req_type(req_type),
    .req_len(req_len), .req_addr(req_addr), .req_tag(req_tag), .req_id(req_id),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .err(err), .tlp_count(tlp_count)
  );

  always #5 clk = ~clk;

  int   tests = 0, failed = 0;
  int   tx_pct = 100, pay_pct = 100, stall_left = 0, pay_pops = 0, mdl_count = 0;
  dwq_t pay_q;

  // Monitor-owned observation state, sampled on the falling edge.
  int   cyc = 0, acc_cnt = 0, acc_cyc = 0, eop_cnt = 0, txv_cnt = 0, pr_cnt = 0;
  int   err_rise = 0, err_high = 0;
  logic err_prev = 1'b0, pay_took = 1'b0;
  dwq_t got_data;
  logic got_sop[$];
  logic got_eop[$];
  int   got_cyc[$];

  always @(negedge clk) begin
    cyc++;
    pay_took = !reset && pay_valid && pay_ready;
    if (!reset && req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; end
    if (!reset && tx_valid) txv_cnt++;
    if (!reset && tx_valid && tx_ready) begin
      got_data.push_back(tx_data);
      got_sop.push_back(tx_sop);
      got_eop.push_back(tx_eop);
      got_cyc.push_back(cyc);
      if (tx_eop) eop_cnt++;
    end
    if (pay_ready) pr_cnt++;
    if (err && !err_prev) err_rise++;
    if (err) err_high++;
    err_prev = err;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic dwq_t model_tlp(input logic [2:0] fmt, input logic [9:0] len,
                                     input logic [31:0] addr, input logic [7:0] tag,
                                     input logic [15:0] id, input dwq_t pay);
    dwq_t q;
    q.push_back((32'(fmt) << 29) + 32'(len));
    q.push_back((32'(id) << 16) + (32'(tag) << 8) + ((len == 10'd1) ? 32'h0F : 32'hFF));
    q.push_back(addr & 32'hFFFF_FFFC);
    if (fmt == 3'b010)
      for (int i = 0; i < int'(len); i++) q.push_back(pay[i]);
    return q;
  endfunction

  task automatic step(input int rdy_mode);
    @(posedge clk);
    #1;
    if (pay_took && pay_q.size() > 0) begin void'(pay_q.pop_front()); pay_pops++; end
    if (rdy_mode < 0) tx_ready = ($urandom_range(99) < tx_pct);
    else              tx_ready = (rdy_mode != 0);
    if (pay_q.size() > 0 && $urandom_range(99) < pay_pct) begin
      pay_valid = 1'b1; pay_data = pay_q[0];
    end else begin
      pay_valid = 1'b0; pay_data = $urandom;
    end
    if (pay_pops == 1 && stall_left > 0) begin stall_left--; pay_valid = 1'b0; end
  endtask

  task automatic send_desc(input logic [2:0] f, input logic [4:0] t, input logic [9:0] l,
                           input logic [31:0] a, input logic [7:0] tg, input logic [15:0] id);
    int base;
    base = acc_cnt;
    req_fmt = f; req_type = t; req_len = l; req_addr = a; req_tag = tg; req_id = id;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(-1);
      if (acc_cnt != base) begin
        req_valid = 1'b0;
        req_fmt = 3'($urandom); req_type = 5'($urandom); req_len = 10'($urandom);
        req_addr = $urandom; req_tag = 8'($urandom); req_id = 16'($urandom);
        return;
      end
    end
    req_valid = 1'b0;
    tests++; failed++;
    $display("FAIL desc_accept: no acceptance seen, required within 100 cycles");
  endtask

  task automatic wait_eop(input int base_eop);
    for (int i = 0; i < 2000; i++) begin
      if (eop_cnt != base_eop) return;
      step(-1);
    end
    tests++; failed++;
    $display("FAIL tlp_done: no eop transfer seen, required within 2000 cycles");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step(0);
    @(negedge clk);
    tests++;
    if ({req_ready, tx_valid, tx_sop, tx_eop, pay_ready, err} !== 6'b0 || tx_data !== 32'h0 || tlp_count !== 8'h0) begin
      failed++;
      $display("FAIL reset_vals: rdy=%b txv=%b sop=%b eop=%b prdy=%b err=%b data=%h cnt=%0d, required all zero",
               req_ready, tx_valid, tx_sop, tx_eop, pay_ready, err, tx_data, tlp_count);
    end
    reset = 1'b0;
    step(0);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || tx_valid !== 1'b0) begin
      failed++; $display("FAIL reset_release: req_ready=%b tx_valid=%b, required 1 and 0", req_ready, tx_valid);
    end
  endtask

  task automatic test_mwr_basic();
    logic [31:0] exp [5] = '{32'h4000_0002, 32'h0100_05FF, 32'h0000_1000, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
    int b, be;
    tx_pct = 100; pay_pct = 100;
    pay_q = '{32'hA5A5_A5A5, 32'h5A5A_5A5A};
    b = got_data.size(); be = eop_cnt;
    send_desc(3'b010, 5'd0, 10'd2, 32'h0000_1000, 8'h05, 16'h0100);
    wait_eop(be);
    @(negedge clk);
    mdl_count = (mdl_count + 1) % 256;
    tests++;
    if (got_data.size() - b !== 5) begin
      failed++; $display("FAIL mwr_count: %0d dwords, required 5", got_data.size() - b);
    end
    for (int i = 0; i < 5 && b + i < got_data.size(); i++) begin
      tests++;
      if (got_data[b+i] !== exp[i] || got_sop[b+i] !== (i == 0) || got_eop[b+i] !== (i == 4)) begin
        failed++;
        $display("FAIL mwr_dw%0d: data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                 i, got_data[b+i], got_sop[b+i], got_eop[b+i], exp[i], i == 0, i == 4);
      end
    end
    if (got_cyc.size() >= b + 5) begin
      tests++;
      if (got_cyc[b] - acc_cyc !== 1 || got_cyc[b+4] - got_cyc[b] !== 4) begin
        failed++;
        $display("FAIL mwr_latency: dw0 %0d cycles after accept, span %0d, required 1 and 4",
                 got_cyc[b] - acc_cyc, got_cyc[b+4] - got_cyc[b]);
      end
    end
    tests++;
    if (tlp_count !== 8'(mdl_count)) begin
      failed++; $display("FAIL mwr_tlp_count: %0d, required %0d", tlp_count, mdl_count);
    end
  endtask

  task automatic test_mrd_basic();
    logic [31:0] exp [3] = '{32'h0000_0001, 32'h0200_110F, 32'h2000_0004};
    int b, be, pr0;
    tx_pct = 100; pay_pct = 100;
    pay_q = '{32'hDEAD_BEEF, 32'h1234_5678};
    b = got_data.size(); be = eop_cnt; pr0 = pr_cnt;
    send_desc(3'b000, 5'd0, 10'd1, 32'h2000_0007, 8'h11, 16'h0200);
    wait_eop(be);
    repeat (3) step(1);
    @(negedge clk);
    mdl_count = (mdl_count + 1) % 256;
    tests++;
    if (got_data.size() - b !== 3) begin
      failed++; $display("FAIL mrd_count: %0d dwords, required 3", got_data.size() - b);
    end
    for (int i = 0; i < 3 && b + i < got_data.size(); i++) begin
      tests++;
      if (got_data[b+i] !== exp[i] || got_sop[b+i] !== (i == 0) || got_eop[b+i] !== (i == 2)) begin
        failed++;
        $display("FAIL mrd_dw%0d: data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                 i, got_data[b+i], got_sop[b+i], got_eop[b+i], exp[i], i == 0, i == 2);
      end
    end
    tests++;
    if (pr_cnt - pr0 !== 0 || pay_q.size() !== 2) begin
      failed++; $display("FAIL mrd_no_payload: pay_ready cycles=%0d left=%0d, required 0 and 2", pr_cnt - pr0, pay_q.size());
    end
    tests++;
    if (tlp_count !== 8'(mdl_count)) begin
      failed++; $display("FAIL mrd_tlp_count: %0d, required %0d", tlp_count, mdl_count);
    end
    pay_q.delete();
  endtask

  task automatic test_backpressure();
    dwq_t e, none;
    logic [9:0] l;
    logic [31:0] a;
    logic [7:0] tg;
    logic [15:0] id;
    int b;
    tx_pct = 100;
    l = 10'($urandom_range(1, 16)); a = $urandom; tg = 8'($urandom); id = 16'($urandom);
    e = model_tlp(3'b000, l, a, tg, id, none);
    b = got_data.size();
    send_desc(3'b000, 5'd0, l, a, tg, id);
    @(negedge clk);
    tests++;
    if (tx_valid !== 1'b1 || tx_sop !== 1'b1 || tx_data !== e[0]) begin
      failed++; $display("FAIL bp_dw0: valid=%b sop=%b data=%h, required 1 1 %h", tx_valid, tx_sop, tx_data, e[0]);
    end
    for (int k = 0; k < 4; k++) begin
      step((k < 3) ? 0 : 1);
      @(negedge clk);
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== e[1] || tx_sop !== 1'b0 || tx_eop !== 1'b0) begin
        failed++;
        $display("FAIL bp_hold%0d: valid=%b data=%h sop=%b eop=%b, required 1 %h 0 0", k, tx_valid, tx_data, tx_sop, tx_eop, e[1]);
      end
    end
    step(1);
    @(negedge clk);
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== e[2] || tx_eop !== 1'b1) begin
      failed++; $display("FAIL bp_dw2: valid=%b data=%h eop=%b, required 1 %h 1", tx_valid, tx_data, tx_eop, e[2]);
    end
    step(1);
    @(negedge clk);
    mdl_count = (mdl_count + 1) % 256;
    tests++;
    if (got_data.size() - b !== 3 || tlp_count !== 8'(mdl_count)) begin
      failed++; $display("FAIL bp_transfers: %0d transfers cnt=%0d, required 3 cnt=%0d", got_data.size() - b, tlp_count, mdl_count);
    end
  endtask

  task automatic test_pay_stall();
    dwq_t pl, e;
    int b, be;
    tx_pct = 100; pay_pct = 100; pay_pops = 0; stall_left = 2;
    for (int i = 0; i < 3; i++) pl.push_back($urandom);
    pay_q = pl;
    e = model_tlp(3'b010, 10'd3, 32'h0000_4444, 8'h33, 16'h0707, pl);
    b = got_data.size(); be = eop_cnt;
    send_desc(3'b010, 5'd0, 10'd3, 32'h0000_4444, 8'h33, 16'h0707);
    wait_eop(be);
    @(negedge clk);
    mdl_count = (mdl_count + 1) % 256;
    tests++;
    if (got_data.size() - b !== 6) begin
      failed++; $display("FAIL stall_count: %0d dwords, required 6", got_data.size() - b);
    end
    for (int i = 0; i < 6 && b + i < got_data.size(); i++) begin
      tests++;
      if (got_data[b+i] !== e[i] || got_eop[b+i] !== (i == 5)) begin
        failed++; $display("FAIL stall_dw%0d: data=%h eop=%b, required %h %b", i, got_data[b+i], got_eop[b+i], e[i], i == 5);
      end
    end
    if (got_cyc.size() >= b + 6) begin
      tests++;
      if (got_cyc[b+4] - got_cyc[b+3] !== 3 || got_cyc[b+5] - got_cyc[b+4] !== 1) begin
        failed++;
        $display("FAIL stall_gap: gaps %0d and %0d cycles, required 3 and 1",
                 got_cyc[b+4] - got_cyc[b+3], got_cyc[b+5] - got_cyc[b+4]);
      end
    end
    tests++;
    if (tlp_count !== 8'(mdl_count)) begin
      failed++; $display("FAIL stall_tlp_count: %0d, required %0d", tlp_count, mdl_count);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] fmts  [4] = '{3'b010, 3'b000, 3'b001, 3'b000};
    logic [4:0] types [4] = '{5'd0, 5'd0, 5'd0, 5'b00100};
    logic [9:0] lens  [4] = '{10'd0, 10'd17, 10'd4, 10'd4};
    int r0, h0, v0;
    tx_pct = 100;
    for (int i = 0; i < 4; i++) begin
      r0 = err_rise; h0 = err_high; v0 = txv_cnt;
      send_desc(fmts[i], types[i], lens[i], $urandom, 8'($urandom), 16'($urandom));
      @(negedge clk);
      tests++;
      if (err !== 1'b1 || req_ready !== 1'b1) begin
        failed++; $display("FAIL illegal%0d_next: err=%b req_ready=%b, required 1 1", i, err, req_ready);
      end
      repeat (4) step(1);
      @(negedge clk);
      tests++;
      if (err_rise - r0 !== 1 || err_high - h0 !== 1 || txv_cnt - v0 !== 0 || tlp_count !== 8'(mdl_count)) begin
        failed++;
        $display("FAIL illegal%0d: pulses=%0d high=%0d txvalid=%0d cnt=%0d, required 1 1 0 %0d",
                 i, err_rise - r0, err_high - h0, txv_cnt - v0, tlp_count, mdl_count);
      end
    end
  endtask

  task automatic test_random();
    dwq_t pl, e;
    logic [2:0] f;
    logic [9:0] l;
    logic [31:0] a;
    logic [7:0] tg;
    logic [15:0] id;
    int b, be, n;
    for (int i = 0; i < 40; i++) begin
      f = ($urandom_range(1) != 0) ? 3'b010 : 3'b000;
      l = 10'($urandom_range(1, 16));
      if (i == 0) begin f = 3'b010; l = 10'd16; end
      if (i == 1) begin f = 3'b010; l = 10'd1; end
      a = $urandom; tg = 8'($urandom); id = 16'($urandom);
      tx_pct = $urandom_range(40, 100); pay_pct = $urandom_range(40, 100);
      pl.delete();
      if (f == 3'b010) for (int k = 0; k < int'(l); k++) pl.push_back($urandom);
      pay_q = pl;
      e = model_tlp(f, l, a, tg, id, pl);
      b = got_data.size(); be = eop_cnt;
      send_desc(f, 5'd0, l, a, tg, id);
      wait_eop(be);
      @(negedge clk);
      mdl_count = (mdl_count + 1) % 256;
      n = got_data.size() - b;
      tests++;
      if (n !== e.size()) begin
        failed++; $display("FAIL rand%0d_len: %0d dwords, required %0d", i, n, e.size());
      end
      for (int k = 0; k < e.size() && k < n; k++) begin
        tests++;
        if (got_data[b+k] !== e[k] || got_sop[b+k] !== (k == 0) || got_eop[b+k] !== (k == e.size() - 1)) begin
          failed++;
          $display("FAIL rand%0d_dw%0d: data=%h sop=%b eop=%b, required %h %b %b",
                   i, k, got_data[b+k], got_sop[b+k], got_eop[b+k], e[k], k == 0, k == e.size() - 1);
        end
      end
      tests++;
      if (tlp_count !== 8'(mdl_count) || pay_q.size() !== 0) begin
        failed++; $display("FAIL rand%0d_cnt: cnt=%0d leftover=%0d, required %0d 0", i, tlp_count, pay_q.size(), mdl_count);
      end
    end
    tx_pct = 100; pay_pct = 100;
  endtask

  task automatic test_reset_mid();
    dwq_t pl, e;
    int b, be;
    tx_pct = 100; pay_pct = 100;
    for (int i = 0; i < 8; i++) pl.push_back($urandom);
    pay_q = pl;
    b = got_data.size(); be = eop_cnt;
    send_desc(3'b010, 5'd0, 10'd8, 32'h0000_8000, 8'h44, 16'h0303);
    for (int i = 0; i < 100 && got_data.size() - b < 5; i++) step(-1);
    reset = 1'b1;
    step(1);
    @(negedge clk);
    tests++;
    if ({tx_valid, tx_sop, tx_eop, pay_ready, err, req_ready} !== 6'b0 || tx_data !== 32'h0 ||
        tlp_count !== 8'h0 || eop_cnt - be !== 0) begin
      failed++;
      $display("FAIL reset_mid: txv=%b sop=%b eop=%b prdy=%b err=%b rdy=%b data=%h cnt=%0d eops=%0d, required all zero",
               tx_valid, tx_sop, tx_eop, pay_ready, err, req_ready, tx_data, tlp_count, eop_cnt - be);
    end
    reset = 1'b0;
    pay_q.delete();
    mdl_count = 0;
    step(1);
    pl.delete();
    pl.push_back($urandom);
    pay_q = pl;
    e = model_tlp(3'b010, 10'd1, 32'h0000_9008, 8'h55, 16'h0404, pl);
    b = got_data.size(); be = eop_cnt;
    send_desc(3'b010, 5'd0, 10'd1, 32'h0000_9008, 8'h55, 16'h0404);
    wait_eop(be);
    @(negedge clk);
    mdl_count = 1;
    tests++;
    if (got_data.size() - b !== 4) begin
      failed++; $display("FAIL post_reset_len: %0d dwords, required 4", got_data.size() - b);
    end
    for (int k = 0; k < 4 && b + k < got_data.size(); k++) begin
      tests++;
      if (got_data[b+k] !== e[k] || got_sop[b+k] !== (k == 0) || got_eop[b+k] !== (k == 3)) begin
        failed++;
        $display("FAIL post_reset_dw%0d: data=%h sop=%b eop=%b, required %h %b %b",
                 k, got_data[b+k], got_sop[b+k], got_eop[b+k], e[k], k == 0, k == 3);
      end
    end
    tests++;
    if (tlp_count !== 8'd1) begin
      failed++; $display("FAIL post_reset_cnt: %0d, required 1", tlp_count);
    end
  endtask

  task automatic test_wrap();
    int be;
    tx_pct = 100;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    for (int i = 0; i < 256; i++) begin
      be = eop_cnt;
      send_desc(3'b000, 5'd0, 10'd1, $urandom, 8'(i), 16'h0001);
      wait_eop(be);
      if (i == 254) begin
        @(negedge clk);
        tests++;
        if (tlp_count !== 8'd255) begin
          failed++; $display("FAIL wrap_255: %0d, required 255", tlp_count);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (tlp_count !== 8'd0) begin
      failed++; $display("FAIL wrap_zero: %0d, required 0", tlp_count);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_fmt = '0; req_type = '0; req_len = '0;
    req_addr = '0; req_tag = '0; req_id = '0; pay_valid = 1'b0; pay_data = '0; tx_ready = 1'b0;
    test_reset();
    test_mwr_basic();
    test_mrd_basic();
    test_backpressure();
    test_pay_stall();
    test_illegal();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
